// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// holds the returned instruction until the consumer takes it, then selects
// the next PC (sequential / jal / branch / jalr).
//
// Optional feature, enabled by defining FETCH_MISALIGN_TRAP_EN:
//   a next PC with bits[1:0] != 0 sends the unit to a sticky TRAP state and
//   raises Misalign. Without the macro the next PC is forced word-aligned.
module fetch_unit #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSrc,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  Stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  InstrValid,
    output logic [31:0]           RetireCount
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  Misalign
`endif
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] JALR_MASK  = ~DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_JAL    = 2'b01;
    localparam logic [1:0] SRC_BRANCH = 2'b10;
    localparam logic [1:0] SRC_JALR   = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        S_TRAP  = 2'd2
`endif
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    capture;
    logic                    consume;
    logic                    req_next;
    logic [DATA_WIDTH-1:0]   target_raw;
    logic [DATA_WIDTH-1:0]   pc_next;

    // Memory address is the PC register itself, so it cannot move mid-request.
    assign imem_addr = PC;

    // Next-PC selection for the instruction currently held.
    always_comb begin
        target_raw = PCPlus4;
        case (PCSrc)
            SRC_SEQ:    target_raw = PCPlus4;
            SRC_JAL:    target_raw = PCTarget;
            SRC_BRANCH: target_raw = BranchTaken ? PCTarget : PCPlus4;
            SRC_JALR:   target_raw = ALUResult & JALR_MASK;
            default:    target_raw = PCPlus4;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        pc_next = target_raw;
`else
        pc_next = target_raw & ALIGN_MASK;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes. An ack only counts while a
    // request is actually outstanding, which also drops acks right after reset.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        consume    = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_req && imem_ack) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!Stall) begin
                    consume    = 1'b1;
                    state_next = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (pc_next[1:0] != 2'b00) begin
                        state_next = S_TRAP;
                    end
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                state_next = S_TRAP;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
        req_next = (state_next == S_FETCH);
    end

    // Request line: low in reset, high in every cycle spent in FETCH after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_req <= 1'b0;
        end else begin
            imem_req <= req_next;
        end
    end

    // Instruction holding register and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Instr      <= '0;
            InstrValid <= 1'b0;
        end else if (capture) begin
            Instr      <= imem_rdata;
            InstrValid <= 1'b1;
        end else if (consume) begin
            InstrValid <= 1'b0;
        end
    end

    // PC, link value and retire counter advance only on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC          <= RESET_PC;
            PCPlus4     <= RESET_PC + PC_STEP;
            RetireCount <= '0;
        end else if (consume) begin
            PC          <= pc_next;
            PCPlus4     <= pc_next + PC_STEP;
            RetireCount <= RetireCount + 32'd1;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Misalign <= 1'b0;
        end else begin
            Misalign <= (state_next == S_TRAP);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch with wait states,
// a table of next-PC selections, jalr alignment/trap, stall hold and reset
// during an outstanding fetch. Works with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  pcsrc;
    logic        branch_taken;
    logic [31:0] pc_target;
    logic [31:0] alu_result;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic [31:0] retire_count;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int tests = 0;
    int fails = 0;
    int exp_retire = 0;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrc       (pcsrc),
        .BranchTaken (branch_taken),
        .PCTarget    (pc_target),
        .ALUResult   (alu_result),
        .Stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instr       (instr),
        .PC          (pc),
        .PCPlus4     (pc_plus4),
        .InstrValid  (instr_valid),
        .RetireCount (retire_count)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .Misalign    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [1:0]  src;
        logic        bt;
        logic [31:0] tgt;
        logic [31:0] alu;
        logic [31:0] next;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, hold the ack off for 'waits' cycles, then answer.
    task automatic serve(input int waits, input logic [31:0] data, input logic [31:0] addr);
        logic [31:0] p4;
        p4 = addr + 32'd4;
        for (int i = 0; i < 8 && !imem_req; i++) step();
        check("req_seen", 32'(imem_req), 32'd1);
        check("req_addr", imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            step();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr_stable", imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        check("instr", instr, data);
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("pc", pc, addr);
        check("pc_plus4", pc_plus4, p4);
        check("hold_req", 32'(imem_req), 32'd0);
    endtask

    // Release the held instruction for one cycle with the given next-PC controls.
    task automatic consume(input logic [1:0] src, input logic bt,
                           input logic [31:0] tgt, input logic [31:0] alu);
        pcsrc        = src;
        branch_taken = bt;
        pc_target    = tgt;
        alu_result   = alu;
        stall        = 1'b0;
        step();
        stall        = 1'b1;
        exp_retire++;
        check("retire_count", retire_count, 32'(exp_retire));
        check("valid_cleared", 32'(instr_valid), 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_retire", retire_count, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misalign", 32'(misalign), 32'd0);
`endif
    endtask

    initial begin
        //          waits rdata          addr           src    bt    tgt            alu            next
        vecs[0] = '{0, 32'h0000_0013, 32'h0000_000C, 2'b00, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0010};
        vecs[1] = '{1, 32'h0000_0463, 32'h0000_0010, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0014};
        vecs[2] = '{0, 32'hFFDF_F06F, 32'h0000_0014, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_0010};
        vecs[3] = '{3, 32'h0000_0463, 32'h0000_0010, 2'b10, 1'b1, 32'h0000_0040, 32'h0,         32'h0000_0040};
        vecs[4] = '{0, 32'h0000_8067, 32'h0000_0040, 2'b11, 1'b0, 32'h0000_0999, 32'h0000_0201, 32'h0000_0200};
        vecs[5] = '{2, 32'h0000_006F, 32'h0000_0200, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC};
        vecs[6] = '{0, 32'h0000_0013, 32'hFFFF_FFFC, 2'b00, 1'b1, 32'h0000_0500, 32'h0,         32'h0000_0000};
        vecs[7] = '{1, 32'h0800_0063, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0080, 32'h0,         32'h0000_0080};
        vecs[8] = '{0, 32'h0000_0013, 32'h0000_0080, 2'b00, 1'b1, 32'h0000_0300, 32'h0,         32'h0000_0084};

        rst          = 1'b0;
        pcsrc        = 2'b00;
        branch_taken = 1'b0;
        pc_target    = 32'h0;
        alu_result   = 32'h0;
        stall        = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;

        // Reset with a stray ack present; nothing may be captured.
        #1 rst = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        step();
        check_reset_state();
        rst      = 1'b0;
        imem_ack = 1'b0;
        check("req_low_after_release", 32'(imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // Three sequential instructions, acks after 0/2/5 wait cycles.
        serve(0, 32'h0050_0093, 32'h0);
        consume(2'b00, 1'b0, 32'h0, 32'h0);
        serve(2, 32'h0010_0113, 32'h4);
        consume(2'b00, 1'b0, 32'h0, 32'h0);
        serve(5, 32'h0020_0193, 32'h8);
        consume(2'b00, 1'b0, 32'h0, 32'h0);
        check("retire_three", retire_count, 32'd3);
        check("seq_next_addr", imem_addr, 32'hC);

        // Table of next-PC selections.
        for (int i = 0; i < 9; i++) begin
            serve(vecs[i].waits, vecs[i].rdata, vecs[i].addr);
            consume(vecs[i].src, vecs[i].bt, vecs[i].tgt, vecs[i].alu);
            check("vec_req", 32'(imem_req), 32'd1);
            check("vec_next_addr", imem_addr, vecs[i].next);
        end

        // jalr to an address with bit1 set.
        serve(0, 32'h0000_8067, 32'h84);
        consume(2'b11, 1'b0, 32'h0, 32'h0000_0103);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_misalign", 32'(misalign), 32'd1);
        check("trap_req", 32'(imem_req), 32'd0);
        check("trap_pc", pc, 32'h102);
        step();
        step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("trap_sticky", 32'(misalign), 32'd1);
        check("trap_req_stays_low", 32'(imem_req), 32'd0);
        check("trap_valid", 32'(instr_valid), 32'd0);
`else
        check("jalr_aligned_req", 32'(imem_req), 32'd1);
        check("jalr_aligned_addr", imem_addr, 32'h100);
`endif

        // Reset pulse, then stall in HOLD and reset during the next fetch wait.
        rst = 1'b1;
        #1;
        exp_retire = 0;
        check_reset_state();
        step();
        rst = 1'b0;
        step();
        serve(1, 32'hDEAD_BEEF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            imem_ack   = (i == 2);
            imem_rdata = 32'h1234_5678;
            step();
            check("stall_instr", instr, 32'hDEAD_BEEF);
            check("stall_pc", pc, 32'h0);
            check("stall_pc_plus4", pc_plus4, 32'h4);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        consume(2'b00, 1'b0, 32'h0, 32'h0);
        check("post_stall_addr", imem_addr, 32'h4);
        step();
        rst = 1'b1;
        #1;
        exp_retire = 0;
        check_reset_state();
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        step();
        rst = 1'b0;
        step();
        imem_ack = 1'b0;
        check("late_ack_instr", instr, 32'h0);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("recover_req", 32'(imem_req), 32'd1);
        check("recover_addr", imem_addr, 32'h0);
        serve(0, 32'h0050_0093, 32'h0);
        consume(2'b00, 1'b0, 32'h0, 32'h0);
        check("recover_next_addr", imem_addr, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
